// File: rtl/wb_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage_reg
// Brief    : Y86-64 memory-to-writeback pipeline register with stall/bubble,
//            sticky halt on first non-AOK status and qualified RF write enables.
//            Optional retired-instruction counter: define WB_RETIRE_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module wb_stage_reg #(
    parameter int                   DATA_W    = 64,
    parameter int                   REG_W     = 4,
    parameter int                   ICODE_W   = 4,
    parameter int                   STAT_W    = 4,
    parameter logic [REG_W-1:0]     RNONE     = 4'hF,
    parameter logic [ICODE_W-1:0]   ICODE_NOP = 4'h1,
    parameter logic [STAT_W-1:0]    STAT_AOK  = 4'h1,
    parameter int                   CNT_W     = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                W_stall,
    input  logic                W_bubble,
    input  logic [STAT_W-1:0]   m_stat,
    input  logic [ICODE_W-1:0]  M_icode,
    input  logic [DATA_W-1:0]   M_valE,
    input  logic [DATA_W-1:0]   m_valM,
    input  logic [REG_W-1:0]    M_dstE,
    input  logic [REG_W-1:0]    M_dstM,
    output logic [STAT_W-1:0]   W_stat,
    output logic [ICODE_W-1:0]  W_icode,
    output logic [DATA_W-1:0]   W_valE,
    output logic [DATA_W-1:0]   W_valM,
    output logic [REG_W-1:0]    W_dstE,
    output logic [REG_W-1:0]    W_dstM,
    output logic                rf_we_e,
    output logic                rf_we_m,
    output logic                halted
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [CNT_W-1:0]    retired_cnt
`endif
);

    logic [STAT_W-1:0]  r_stat;
    logic [ICODE_W-1:0] r_icode;
    logic [DATA_W-1:0]  r_valE;
    logic [DATA_W-1:0]  r_valM;
    logic [REG_W-1:0]   r_dstE;
    logic [REG_W-1:0]   r_dstM;
    logic               r_halted;

    // Halt outranks stall, stall outranks bubble.
    logic w_load;
    logic w_take_m;

    assign w_load   = !r_halted && !W_stall;
    assign w_take_m = w_load && !W_bubble;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat   <= STAT_AOK;
            r_icode  <= ICODE_NOP;
            r_valE   <= '0;
            r_valM   <= '0;
            r_dstE   <= RNONE;
            r_dstM   <= RNONE;
            r_halted <= 1'b0;
        end else if (w_load) begin
            if (W_bubble) begin
                r_stat  <= STAT_AOK;
                r_icode <= ICODE_NOP;
                r_valE  <= '0;
                r_valM  <= '0;
                r_dstE  <= RNONE;
                r_dstM  <= RNONE;
            end else begin
                r_stat   <= m_stat;
                r_icode  <= M_icode;
                r_valE   <= M_valE;
                r_valM   <= m_valM;
                r_dstE   <= M_dstE;
                r_dstM   <= M_dstM;
                r_halted <= (m_stat != STAT_AOK);
            end
        end
    end

    assign W_stat  = r_stat;
    assign W_icode = r_icode;
    assign W_valE  = r_valE;
    assign W_valM  = r_valM;
    assign W_dstE  = r_dstE;
    assign W_dstM  = r_dstM;
    assign halted  = r_halted;

    // Enables look only at the W registers so a faulting entry never writes.
    assign rf_we_e = (r_dstE != RNONE) && (r_stat == STAT_AOK);
    assign rf_we_m = (r_dstM != RNONE) && (r_stat == STAT_AOK);

`ifdef WB_RETIRE_CNT_EN
    logic [CNT_W-1:0] r_retired_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_retired_cnt <= '0;
        end else if (w_take_m && (m_stat == STAT_AOK) && (M_icode != ICODE_NOP)
                     && (r_retired_cnt != {CNT_W{1'b1}})) begin
            r_retired_cnt <= r_retired_cnt + CNT_W'(1);
        end
    end

    assign retired_cnt = r_retired_cnt;
`else
    // Counter width only matters when the counter is built.
    if (CNT_W > 0) begin : g_no_retire_cnt
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_stage_reg
// Brief    : Table-driven, hand-sequence and randomized checks of wb_stage_reg.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_stage_reg;

    localparam int CNT_W = 4;

    logic        clk = 1'b0;
    logic        rst, W_stall, W_bubble;
    logic [3:0]  m_stat, M_icode, M_dstE, M_dstM;
    logic [63:0] M_valE, m_valM;
    logic [3:0]  W_stat, W_icode, W_dstE, W_dstM;
    logic [63:0] W_valE, W_valM;
    logic        rf_we_e, rf_we_m, halted;
`ifdef WB_RETIRE_CNT_EN
    logic [CNT_W-1:0] retired_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wb_stage_reg #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .W_stall(W_stall), .W_bubble(W_bubble),
        .m_stat(m_stat), .M_icode(M_icode), .M_valE(M_valE), .m_valM(m_valM),
        .M_dstE(M_dstE), .M_dstM(M_dstM),
        .W_stat(W_stat), .W_icode(W_icode), .W_valE(W_valE), .W_valM(W_valM),
        .W_dstE(W_dstE), .W_dstM(W_dstM),
        .rf_we_e(rf_we_e), .rf_we_m(rf_we_m), .halted(halted)
`ifdef WB_RETIRE_CNT_EN
        , .retired_cnt(retired_cnt)
`endif
    );

    typedef struct {
        logic        r, s, b;
        logic [3:0]  st, ic;
        logic [63:0] ve, vm;
        logic [3:0]  de, dm;
        logic [3:0]  est, eic;
        logic [63:0] eve, evm;
        logic [3:0]  ede, edm;
        logic        ewe, ewm, eh;
    } vec_t;

    typedef struct {
        logic [3:0]  stat, icode;
        logic [63:0] valE, valM;
        logic [3:0]  dstE, dstM;
    } wrec_t;

    function automatic vec_t mk(logic r, logic s, logic b,
                                logic [3:0] st, logic [3:0] ic,
                                logic [63:0] ve, logic [63:0] vm,
                                logic [3:0] de, logic [3:0] dm,
                                logic [3:0] est, logic [3:0] eic,
                                logic [63:0] eve, logic [63:0] evm,
                                logic [3:0] ede, logic [3:0] edm,
                                logic ewe, logic ewm, logic eh);
        vec_t v;
        v.r = r; v.s = s; v.b = b; v.st = st; v.ic = ic; v.ve = ve; v.vm = vm;
        v.de = de; v.dm = dm; v.est = est; v.eic = eic; v.eve = eve; v.evm = evm;
        v.ede = ede; v.edm = edm; v.ewe = ewe; v.ewm = ewm; v.eh = eh;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic b,
                         input logic [3:0] st, input logic [3:0] ic,
                         input logic [63:0] ve, input logic [63:0] vm,
                         input logic [3:0] de, input logic [3:0] dm);
        rst = r; W_stall = s; W_bubble = b; m_stat = st; M_icode = ic;
        M_valE = ve; m_valM = vm; M_dstE = de; M_dstM = dm;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Behavioural reference: state of W, sticky halt and saturating count.
    wrec_t        mw;
    logic         mh;
    int unsigned  mcnt;
    wrec_t        BUB = '{stat: 4'h1, icode: 4'h1, valE: 64'd0, valM: 64'd0, dstE: 4'hF, dstM: 4'hF};

    task automatic model_edge();
        if (rst) begin
            mw = BUB; mh = 1'b0; mcnt = 0;
        end else if (mh || W_stall) begin
            // hold
        end else if (W_bubble) begin
            mw = BUB;
        end else begin
            mw = '{stat: m_stat, icode: M_icode, valE: M_valE, valM: m_valM,
                   dstE: M_dstE, dstM: M_dstM};
            if (m_stat != 4'h1) mh = 1'b1;
            else if (M_icode != 4'h1 && mcnt < (2**CNT_W - 1)) mcnt++;
        end
    endtask

    vec_t vecs[19];

    initial begin
        //            r  s  b  st  ic  valE        valM     dE  dM | est eic eve       evm      edE edM we_e we_m h
        vecs[0]  = mk(1, 0, 0, 2, 6, 64'd77,     64'd88,  2, 3,    1, 1, 64'd0,    64'd0,   15, 15, 0, 0, 0);
        vecs[1]  = mk(1, 1, 1, 2, 6, 64'd77,     64'd88,  2, 3,    1, 1, 64'd0,    64'd0,   15, 15, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 1, 6, -64'd5,     64'd0,   3, 15,   1, 6, -64'd5,   64'd0,   3,  15, 1, 0, 0);
        vecs[3]  = mk(0, 1, 0, 1, 5, 64'd99,     64'd123, 7, 8,    1, 6, -64'd5,   64'd0,   3,  15, 1, 0, 0);
        vecs[4]  = mk(0, 1, 0, 1, 2, 64'd11,     64'd22,  1, 1,    1, 6, -64'd5,   64'd0,   3,  15, 1, 0, 0);
        vecs[5]  = mk(0, 1, 0, 2, 0, 64'd1,      64'd2,   1, 2,    1, 6, -64'd5,   64'd0,   3,  15, 1, 0, 0);
        vecs[6]  = mk(0, 1, 1, 1, 6, 64'd9,      64'd9,   4, 4,    1, 6, -64'd5,   64'd0,   3,  15, 1, 0, 0);
        vecs[7]  = mk(0, 0, 1, 1, 6, 64'd5,      64'd5,   2, 2,    1, 1, 64'd0,    64'd0,   15, 15, 0, 0, 0);
        vecs[8]  = mk(0, 0, 0, 1, 5, 64'd100,    -64'd7,  4, 4,    1, 5, 64'd100,  -64'd7,  4,  4,  1, 1, 0);
        vecs[9]  = mk(0, 0, 0, 2, 0, 64'd1,      64'd2,   5, 6,    2, 0, 64'd1,    64'd2,   5,  6,  0, 0, 1);
        vecs[10] = mk(0, 0, 0, 1, 6, 64'd10,     64'd20,  1, 2,    2, 0, 64'd1,    64'd2,   5,  6,  0, 0, 1);
        vecs[11] = mk(0, 0, 0, 1, 6, 64'd11,     64'd21,  1, 2,    2, 0, 64'd1,    64'd2,   5,  6,  0, 0, 1);
        vecs[12] = mk(0, 0, 0, 1, 3, 64'd12,     64'd22,  3, 3,    2, 0, 64'd1,    64'd2,   5,  6,  0, 0, 1);
        vecs[13] = mk(0, 0, 0, 1, 6, 64'd13,     64'd23,  1, 2,    2, 0, 64'd1,    64'd2,   5,  6,  0, 0, 1);
        vecs[14] = mk(0, 0, 0, 1, 6, 64'd14,     64'd24,  1, 2,    2, 0, 64'd1,    64'd2,   5,  6,  0, 0, 1);
        vecs[15] = mk(0, 0, 1, 1, 6, 64'd15,     64'd25,  1, 2,    2, 0, 64'd1,    64'd2,   5,  6,  0, 0, 1);
        vecs[16] = mk(1, 0, 0, 1, 6, 64'd16,     64'd26,  1, 2,    1, 1, 64'd0,    64'd0,   15, 15, 0, 0, 0);
        vecs[17] = mk(0, 0, 0, 3, 5, 64'd0,      64'd42,  15, 4,   3, 5, 64'd0,    64'd42,  15, 4,  0, 0, 1);
        vecs[18] = mk(1, 0, 0, 1, 6, 64'd3,      64'd4,   1, 2,    1, 1, 64'd0,    64'd0,   15, 15, 0, 0, 0);

        drive(1, 0, 0, 1, 1, 0, 0, 15, 15);
        @(negedge clk);
        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].r, vecs[i].s, vecs[i].b, vecs[i].st, vecs[i].ic,
                  vecs[i].ve, vecs[i].vm, vecs[i].de, vecs[i].dm);
            step();
            chk($sformatf("v%0d.stat", i),  64'(W_stat),  64'(vecs[i].est));
            chk($sformatf("v%0d.icode", i), 64'(W_icode), 64'(vecs[i].eic));
            chk($sformatf("v%0d.valE", i),  W_valE,       vecs[i].eve);
            chk($sformatf("v%0d.valM", i),  W_valM,       vecs[i].evm);
            chk($sformatf("v%0d.dstE", i),  64'(W_dstE),  64'(vecs[i].ede));
            chk($sformatf("v%0d.dstM", i),  64'(W_dstM),  64'(vecs[i].edm));
            chk($sformatf("v%0d.we_e", i),  64'(rf_we_e), 64'(vecs[i].ewe));
            chk($sformatf("v%0d.we_m", i),  64'(rf_we_m), 64'(vecs[i].ewm));
            chk($sformatf("v%0d.halted", i), 64'(halted), 64'(vecs[i].eh));
        end

`ifdef WB_RETIRE_CNT_EN
        // Saturation: 20 AOK loads of icode 6 after reset, count tops out at 15.
        drive(1, 0, 0, 1, 6, 0, 0, 15, 15);
        step();
        chk("cnt.reset", 64'(retired_cnt), 64'd0);
        for (int i = 1; i <= 20; i++) begin
            drive(0, 0, 0, 1, 6, 64'(i), 64'(i), 3, 15);
            step();
            chk($sformatf("cnt.load%0d", i), 64'(retired_cnt), 64'((i > 15) ? 15 : i));
        end
        // Stall and bubble must not count.
        drive(0, 1, 0, 1, 6, 0, 0, 3, 15);
        step();
        drive(1, 0, 0, 1, 6, 0, 0, 3, 15);
        step();
        drive(0, 1, 0, 1, 6, 0, 0, 3, 15);
        step();
        drive(0, 0, 1, 1, 6, 0, 0, 3, 15);
        step();
        chk("cnt.stall_bubble", 64'(retired_cnt), 64'd0);
`endif

        // Randomized phase against the reference model.
        for (int i = 0; i < 600; i++) begin
            drive((i == 0) || ($urandom_range(0, 31) == 0),
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0,
                  ($urandom_range(0, 19) == 0) ? 4'($urandom_range(2, 4)) : 4'h1,
                  4'($urandom_range(0, 11)),
                  {$urandom, $urandom}, {$urandom, $urandom},
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            model_edge();
            step();
            chk($sformatf("r%0d.W", i),
                {W_stat, W_icode, W_dstE, W_dstM, 48'd0},
                {mw.stat, mw.icode, mw.dstE, mw.dstM, 48'd0});
            chk($sformatf("r%0d.valE", i), W_valE, mw.valE);
            chk($sformatf("r%0d.valM", i), W_valM, mw.valM);
            chk($sformatf("r%0d.ctl", i), {61'd0, rf_we_e, rf_we_m, halted},
                {61'd0, (mw.dstE != 4'hF) && (mw.stat == 4'h1),
                        (mw.dstM != 4'hF) && (mw.stat == 4'h1), mh});
`ifdef WB_RETIRE_CNT_EN
            chk($sformatf("r%0d.cnt", i), 64'(retired_cnt), 64'(mcnt));
`endif
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
